// File: rtl/rock_ramp_scheduler.sv
// Applies amplitude/frequency targets to the cradle motor one step at a time on
// slow ticks, confirms settling, and ramps down to 0/0 quickly on stop.
module rock_ramp_scheduler #(
   parameter int STEP_TICKS   = 4,
   parameter int SETTLE_TICKS = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       stop,
   input  logic       target_valid,
   input  logic [2:0] target_amp,
   input  logic [2:0] target_freq,
   output logic       target_ready,
   output logic [2:0] amp_out,
   output logic [2:0] freq_out,
   output logic       busy,
   output logic       settled,
   output logic       step
);

   typedef enum logic [1:0] {IDLE, RAMP, SETTLE, STOP} state_t;

   localparam logic [3:0] STEP_LAST   = 4'(STEP_TICKS - 1);
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_TICKS - 1);

   state_t     state, state_n;
   logic [3:0] cnt, cnt_n;
   logic [2:0] tamp, tfreq, tamp_n, tfreq_n, amp_n, freq_n;
   logic       step_n, settled_n, accept;

   function automatic logic [2:0] toward(input logic [2:0] cur, input logic [2:0] tgt);
      if (cur < tgt)      return cur + 3'd1;
      else if (cur > tgt) return cur - 3'd1;
      else                return cur;
   endfunction

   assign target_ready = !reset && !stop && ((state == IDLE) || (state == SETTLE));
   assign accept       = target_valid && target_ready;
   assign busy         = (state == RAMP) || (state == STOP);

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      tamp_n    = tamp;
      tfreq_n   = tfreq;
      amp_n     = amp_out;
      freq_n    = freq_out;
      step_n    = 1'b0;
      settled_n = 1'b0;
      if (stop && state != STOP) begin
         state_n = STOP;
         tamp_n  = 3'd0;
         tfreq_n = 3'd0;
         cnt_n   = 4'd0;
      end else if (accept) begin
         // a tick arriving with the accept is not counted in the new state
         tamp_n  = target_amp;
         tfreq_n = target_freq;
         cnt_n   = 4'd0;
         state_n = (target_amp == amp_out && target_freq == freq_out) ? SETTLE : RAMP;
      end else begin
         case (state)
            RAMP: if (tick) begin
               if (cnt == STEP_LAST) begin
                  cnt_n  = 4'd0;
                  amp_n  = toward(amp_out, tamp);
                  freq_n = toward(freq_out, tfreq);
                  step_n = (amp_n != amp_out) || (freq_n != freq_out);
                  if (amp_n == tamp && freq_n == tfreq) state_n = SETTLE;
               end else begin
                  cnt_n = cnt + 4'd1;
               end
            end
            SETTLE: if (tick) begin
               if (cnt == SETTLE_LAST) begin
                  cnt_n     = 4'd0;
                  settled_n = 1'b1;
                  state_n   = IDLE;
               end else begin
                  cnt_n = cnt + 4'd1;
               end
            end
            STOP: begin
               // exit only once fully down and the request has been released
               if (amp_out == 3'd0 && freq_out == 3'd0 && !stop) begin
                  state_n = IDLE;
               end else if (tick) begin
                  amp_n  = toward(amp_out, 3'd0);
                  freq_n = toward(freq_out, 3'd0);
                  step_n = (amp_out != 3'd0) || (freq_out != 3'd0);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         tamp     <= 3'd0;
         tfreq    <= 3'd0;
         amp_out  <= 3'd0;
         freq_out <= 3'd0;
         step     <= 1'b0;
         settled  <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         tamp     <= tamp_n;
         tfreq    <= tfreq_n;
         amp_out  <= amp_n;
         freq_out <= freq_n;
         step     <= step_n;
         settled  <= settled_n;
      end
   end

endmodule

// File: tb/tb_rock_ramp_scheduler.sv
// Bench for rock_ramp_scheduler: directed scenarios plus random traffic, all
// checked each cycle against a tick-counting reference model.
module tb_rock_ramp_scheduler;
   localparam int STEP_TICKS   = 4;
   localparam int SETTLE_TICKS = 8;
   localparam int M_IDLE = 0, M_RAMP = 1, M_SETTLE = 2, M_STOP = 3;

   logic       clk = 1'b0;
   logic       reset, tick, stop, target_valid;
   logic [2:0] target_amp, target_freq;
   logic       target_ready, busy, settled, step;
   logic [2:0] amp_out, freq_out;

   always #5 clk = ~clk;

   rock_ramp_scheduler #(.STEP_TICKS(STEP_TICKS), .SETTLE_TICKS(SETTLE_TICKS)) dut (
      .clk(clk), .reset(reset), .tick(tick), .stop(stop),
      .target_valid(target_valid), .target_amp(target_amp), .target_freq(target_freq),
      .target_ready(target_ready), .amp_out(amp_out), .freq_out(freq_out),
      .busy(busy), .settled(settled), .step(step));

   int n_tests = 0, n_fail = 0;
   // model: mode, applied/target settings, ticks since entering the mode
   int m_mode = M_IDLE, m_amp = 0, m_freq = 0, m_ta = 0, m_tf = 0, m_ticks = 0;
   bit m_step = 0, m_settled = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int mv(input int c, input int t);
      return (c < t) ? c + 1 : (c > t) ? c - 1 : c;
   endfunction

   function automatic bit m_ready(input bit r, input bit stp);
      return !r && !stp && (m_mode == M_IDLE || m_mode == M_SETTLE);
   endfunction

   task automatic model(input bit r, input bit tk, input bit stp, input bit vld,
                        input int a, input int f);
      bit rdy;
      rdy = m_ready(r, stp);
      m_step = 0;
      m_settled = 0;
      if (r) begin
         m_mode = M_IDLE; m_amp = 0; m_freq = 0; m_ta = 0; m_tf = 0; m_ticks = 0;
      end else if (stp && m_mode != M_STOP) begin
         m_mode = M_STOP; m_ta = 0; m_tf = 0;
      end else if (vld && rdy) begin
         m_ta = a; m_tf = f; m_ticks = 0;
         m_mode = (a == m_amp && f == m_freq) ? M_SETTLE : M_RAMP;
      end else begin
         case (m_mode)
            M_RAMP: if (tk) begin
               m_ticks++;
               if (m_ticks % STEP_TICKS == 0) begin
                  m_amp = mv(m_amp, m_ta);
                  m_freq = mv(m_freq, m_tf);
                  m_step = 1;
                  if (m_amp == m_ta && m_freq == m_tf) begin
                     m_mode = M_SETTLE; m_ticks = 0;
                  end
               end
            end
            M_SETTLE: if (tk) begin
               m_ticks++;
               if (m_ticks == SETTLE_TICKS) begin
                  m_settled = 1; m_mode = M_IDLE;
               end
            end
            M_STOP: begin
               if (m_amp == 0 && m_freq == 0 && !stp) m_mode = M_IDLE;
               else if (tk) begin
                  m_step = (m_amp > 0) || (m_freq > 0);
                  m_amp = mv(m_amp, 0);
                  m_freq = mv(m_freq, 0);
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic cyc(input bit r, input bit tk, input bit stp, input bit vld,
                      input int a, input int f);
      reset = r; tick = tk; stop = stp; target_valid = vld;
      target_amp = 3'(a); target_freq = 3'(f);
      #1;
      chk("ready", int'(target_ready), int'(m_ready(r, stp)));
      @(posedge clk);
      model(r, tk, stp, vld, a & 7, f & 7);
      #1;
      chk("amp", int'(amp_out), m_amp);
      chk("freq", int'(freq_out), m_freq);
      chk("step", int'(step), int'(m_step));
      chk("settled", int'(settled), int'(m_settled));
      chk("busy", int'(busy), int'(m_mode == M_RAMP || m_mode == M_STOP));
   endtask

   task automatic tick_n(input int n, input bit stp);
      for (int i = 0; i < n; i++) begin
         cyc(0, 0, stp, 0, 0, 0);
         cyc(0, 1, stp, 0, 0, 0);
      end
   endtask

   initial begin
      bit stp_r;
      // reset state
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      chk("rst_amp", int'(amp_out), 0);
      chk("rst_busy", int'(busy), 0);

      // ramp to 3/2, then settle
      cyc(0, 0, 0, 1, 3, 2);
      tick_n(12, 0);
      chk("s1_amp", int'(amp_out), 3);
      chk("s1_freq", int'(freq_out), 2);
      tick_n(8, 0);

      // target equals current output: straight to settle
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      tick_n(8, 0);

      // ramp to 5/5, then stop down to 0/0
      cyc(0, 0, 0, 1, 5, 5);
      tick_n(29, 0);
      tick_n(20, 1);
      chk("s3_amp", int'(amp_out), 0);
      chk("s3_freq", int'(freq_out), 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);

      // retarget during settle
      cyc(0, 0, 0, 1, 3, 3);
      tick_n(14, 0);
      cyc(0, 0, 0, 1, 1, 6);
      tick_n(12, 0);
      chk("s4_amp", int'(amp_out), 1);
      chk("s4_freq", int'(freq_out), 6);
      tick_n(8, 0);

      // reset mid-ramp with target_valid held
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 7, 1);
      tick_n(16, 0);
      chk("s5_pre_amp", int'(amp_out), 4);
      cyc(1, 1, 0, 1, 6, 6);
      cyc(1, 0, 0, 1, 6, 6);
      chk("s5_amp", int'(amp_out), 0);
      tick_n(10, 0);
      chk("s5_hold", int'(amp_out), 0);

      // accept coinciding with a tick
      cyc(0, 1, 0, 1, 7, 7);
      tick_n(3, 0);
      chk("s6_early", int'(amp_out), 0);
      tick_n(1, 0);
      chk("s6_first", int'(amp_out), 1);

      // random traffic
      stp_r = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, stp_r ? 39 : 79) == 0) stp_r = !stp_r;
         cyc($urandom_range(0, 499) == 0, $urandom_range(0, 2) == 0, stp_r,
             $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/rock_ramp_scheduler.md
Name: rock_ramp_scheduler

Overview:
- Sits between the rocking controller and the Output module in the cradle top level.
- Accepts target amplitude/frequency settings (3-bit each) through a valid/ready handshake.
- Ramps the applied settings one step at a time on slow enable ticks, so the cradle motor never jumps; confirms settling, and runs a fast controlled ramp-down on stop.

Parameters:
- STEP_TICKS, 4, number of tick pulses between ramp steps in RAMP (legal range 1..15)
- SETTLE_TICKS, 8, number of tick pulses held at target before reporting settled (legal range 1..15)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- tick  input  1  one-clk enable pulse from the clock-delay block (slow4); all timing counts these
- stop  input  1  level; request ramp-down to 0/0 (stress error or external stop)
- target_valid  input  1  target setting offered
- target_amp  input  3  requested amplitude 0..7
- target_freq  input  3  requested frequency 0..7
- target_ready  output  1  block accepts target this cycle
- amp_out  output  3  applied amplitude, to Output module
- freq_out  output  3  applied frequency, to Output module
- busy  output  1  high in RAMP or STOP
- settled  output  1  one-clk pulse when settle hold completes
- step  output  1  one-clk pulse on every cycle amp_out/freq_out change

Behaviour:
- Reset (sync, active-high, wins over all inputs): state IDLE, amp_out=0, freq_out=0, target registers=0, tick counter=0, settled=0, step=0, busy=0, target_ready=0 in the reset cycle.
- States: IDLE, RAMP, SETTLE, STOP. target_ready = (state==IDLE or SETTLE) and !stop; combinational from state and stop.
- Accept = target_valid & target_ready; target latched on the accepting clk edge. Holding target_valid without ready is legal; nothing is latched.
- IDLE: on accept, if target equals (amp_out,freq_out), go to SETTLE; otherwise go to RAMP. Tick counter cleared on either entry.
- RAMP: counter increments on each tick. On the tick where counter==STEP_TICKS-1, the counter clears, each of amp_out/freq_out moves 1 toward its target independently (a field at target holds), and step pulses in that cycle.
  - When both fields equal target after a step, go to SETTLE the next cycle with the counter cleared.
  - First step lands exactly STEP_TICKS ticks after entry.
- SETTLE: counter increments per tick. On the tick with counter==SETTLE_TICKS-1, pulse settled and go to IDLE.
  - Accept during SETTLE (retarget): same rule as IDLE; the settle count restarts.
  - Retarget and settle completion on the same cycle: the accept wins and settled does not pulse.
- STOP: entered from any state the cycle after stop is seen high. Priority: reset > stop > accept.
  - Ramps both fields down by 1 on every tick; no STEP_TICKS spacing.
  - When amp_out==0, freq_out==0 and stop==0, go to IDLE. Stay in STOP while stop is held, even at 0/0.
  - Target registers cleared to 0 on STOP entry. If already at 0/0 on entry, there is no step pulse.
- Arithmetic: unsigned 3-bit. Saturation is inherent because steps only move toward targets in 0..7; no wrap from 7 to 0 or 0 to 7.
- tick while in IDLE has no effect. tick and accept on the same cycle: the accept is processed, and the tick is not counted in the new state.
- busy = state in {RAMP, STOP}.
- Latency: accept to first step = STEP_TICKS ticks. amp_out/freq_out are registered outputs.

Test Plan:
- Reset, then accept target 3/2 in IDLE with STEP_TICKS=4 -> steps at ticks 4, 8, 12: (1,1), (2,2), (3,2). After 8 more ticks, settled pulses once and state is IDLE; busy high from accept until entry to SETTLE.
- Accept 0/0 while at 0/0 -> no RAMP and no step; settled pulses after 8 ticks. target_ready stays high throughout.
- At 5/5, stop asserted for 20 ticks -> outputs 4/4, 3/3 … 0/0 on consecutive ticks; target_ready=0 throughout. Drop stop -> IDLE the next cycle and target_ready=1.
- During SETTLE at 3/3, accept 1/6 -> re-enters RAMP, no settled pulse. Steps yield (2,4), (1,5), (1,6).
- Reset asserted mid-RAMP at 4/1 -> next cycle outputs 0/0, IDLE, no step pulse. target_valid held high during reset is not latched.
- In IDLE, target_valid and tick on the same cycle with target 7/7 -> accepted; the tick is not counted, and the first step arrives 4 ticks later.
